// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: sequencer states, Booth digit
// encoding and default operand width, common to the multiplier and divider.
package arith_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  // Radix-4 Booth digit as sign plus magnitude; mag is only ever 0, 1 or 2.
  typedef struct packed {
    logic       neg;
    logic [1:0] mag;
  } booth_dig_t;

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: maps an overlapping multiplier triplet to a signed
// digit in {-2,-1,0,+1,+2}, packed as {neg, mag[1:0]}.
module booth_recode
  import arith_pkg::*;
(
  input  logic [2:0] trip,
  output logic [2:0] dig
);

  booth_dig_t d;

  always_comb begin
    d = '0;
    case (trip)
      3'b001, 3'b010: d = '{neg: 1'b0, mag: 2'd1};
      3'b011:         d = '{neg: 1'b0, mag: 2'd2};
      3'b100:         d = '{neg: 1'b1, mag: 2'd2};
      3'b101, 3'b110: d = '{neg: 1'b1, mag: 2'd1};
      default:        d = '0;
    endcase
  end

  assign dig = d;

endmodule

// File: rtl/booth4_mult.sv
// Iterative radix-4 Booth multiplier: unsigned W x W product, one recoded
// digit per clock, enable/done handshake matching the SRT divider.
module booth4_mult
  import arith_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           enable,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [2*W-1:0] P,
  output logic           busy,
  output logic           done
);

  localparam int NDIG = (W + 2) / 2;
  localparam int AW   = 2 * W + 2;
  localparam int CW   = $clog2(NDIG);

  state_t           state, state_n;
  logic [AW-1:0]    acc, acc_n;
  logic [W+2:0]     mreg, mreg_n;
  logic [W-1:0]     mcand, mcand_n;
  logic [CW-1:0]    count, count_n;
  logic [2*W-1:0]   p_n;
  logic             busy_n, done_n;

  logic [2:0]       dig_bits;
  booth_dig_t       dig;
  logic [AW-1:0]    pp, pp_sh, acc_sum;
  logic             last;

  booth_recode u_recode (
    .trip (mreg[2:0]),
    .dig  (dig_bits)
  );

  assign dig = booth_dig_t'(dig_bits);

  // Partial product is formed at full accumulator width so negation wraps
  // modulo 2^(2W+2); the top two bits cancel out by the final digit.
  always_comb begin
    pp = '0;
    case (dig.mag)
      2'd1:    pp = {{(AW-W){1'b0}}, mcand};
      2'd2:    pp = {{(AW-W){1'b0}}, mcand} << 1;
      default: pp = '0;
    endcase
    if (dig.neg) pp = ~pp + 1'b1;
    pp_sh   = pp << {count, 1'b0};
    acc_sum = acc + pp_sh;
    last    = (count == CW'(NDIG - 1));
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    mreg_n  = mreg;
    mcand_n = mcand;
    count_n = count;
    p_n     = P;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          mcand_n = A;
          mreg_n  = {2'b00, B, 1'b0};
          acc_n   = '0;
          count_n = '0;
          state_n = CALC;
        end
      end
      CALC: begin
        acc_n   = acc_sum;
        mreg_n  = mreg >> 2;
        count_n = count + 1'b1;
        if (last) begin
          p_n     = acc_sum[2*W-1:0];
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == CALC);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      acc   <= '0;
      mreg  <= '0;
      mcand <= '0;
      count <= '0;
      P     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      mreg  <= mreg_n;
      mcand <= mcand_n;
      count <= count_n;
      P     <= p_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule
